// File: rtl/key_instr_issuer.sv
// Debounces raw key presses, maps them to 3-bit instructions and presents each for a fixed hold window.
// Optional auto-repeat while the key stays held is compiled in when KEY_AUTOREPEAT_EN is defined.
module key_instr_issuer #(
  parameter int DEB_CYCLES    = 16,
  parameter int HOLD_CYCLES   = 4,
  parameter int CNT_W         = 16,
  parameter int REPEAT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_down,
  input  logic       ready,
  output logic       new_instruction,
  output logic [2:0] instruction,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    WAIT_KEY,
    DEB_PRESS,
    ISSUE,
    WAIT_READY,
    DEB_RELEASE
  } state_t;

  localparam logic [2:0]       IDLE_CODE = 3'b101;
  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  // Parameter sanity checks resolved at elaboration.
  if (DEB_CYCLES < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_range
    $error("key_instr_issuer: parameter below its minimum");
  end
  if ((DEB_CYCLES >> CNT_W) != 0 || (HOLD_CYCLES >> CNT_W) != 0 ||
      (REPEAT_CYCLES >> CNT_W) != 0) begin : g_bad_width
    $error("key_instr_issuer: CNT_W too narrow for the configured cycle counts");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [3:0]       r_key;
  logic [3:0]       w_key_next;
  logic             w_err_next;
  logic             w_mapped;
  logic             w_rpt_fire;

  logic             r_new_instruction;
  logic [2:0]       r_instruction;
  logic             r_busy;
  logic             r_err;

  assign w_mapped  = (r_key <= 4'h4);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] r_rpt_cnt;
  logic             w_rpt_hold;

  assign w_rpt_hold = (r_state == DEB_RELEASE) && key_down && (key_code == r_key);
  assign w_rpt_fire = w_rpt_hold && w_mapped && (r_rpt_cnt >= RPT_LAST);

  // Hold counter only advances while the same key stays down after release debounce began.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rpt_cnt <= '0;
    end else if (w_rpt_hold && !w_rpt_fire) begin
      r_rpt_cnt <= (r_rpt_cnt == '1) ? r_rpt_cnt : r_rpt_cnt + 1'b1;
    end else begin
      r_rpt_cnt <= '0;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_KEY;
      r_cnt   <= '0;
      r_key   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_key   <= w_key_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_key_next   = r_key;
    w_err_next   = 1'b0;
    unique case (r_state)
      WAIT_KEY: begin
        w_cnt_next = '0;
        if (key_down) begin
          w_key_next   = key_code;
          w_state_next = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (!key_down || key_code != r_key) begin
          w_cnt_next   = '0;
          w_state_next = WAIT_KEY;
        end else if (r_cnt >= DEB_MAX) begin
          w_cnt_next = '0;
          if (w_mapped) begin
            w_state_next = ISSUE;
          end else begin
            w_err_next   = 1'b1;
            w_state_next = DEB_RELEASE;
          end
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      ISSUE: begin
        if (r_cnt >= HOLD_LAST) begin
          w_cnt_next   = '0;
          w_state_next = WAIT_READY;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      WAIT_READY: begin
        w_cnt_next = '0;
        if (ready) begin
          w_state_next = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        if (w_rpt_fire) begin
          w_cnt_next   = '0;
          w_state_next = ISSUE;
        end else if (key_down) begin
          w_cnt_next = '0;
        end else if (r_cnt >= DEB_LAST) begin
          w_cnt_next   = '0;
          w_state_next = WAIT_KEY;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = WAIT_KEY;
      end
    endcase
  end

  // Output stage: registered view of the current state, so issue starts one cycle after ISSUE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_new_instruction <= 1'b0;
      r_instruction     <= IDLE_CODE;
      r_busy            <= 1'b0;
      r_err             <= 1'b0;
    end else begin
      r_new_instruction <= (r_state == ISSUE);
      r_instruction     <= (r_state == ISSUE) ? r_key[2:0] : IDLE_CODE;
      r_busy            <= (r_state != WAIT_KEY);
      r_err             <= w_err_next;
    end
  end

  assign new_instruction = r_new_instruction;
  assign instruction     = r_instruction;
  assign busy            = r_busy;
  assign err             = r_err;

endmodule

// File: tb/tb_key_instr_issuer.sv
// Directed, table-driven bench for key_instr_issuer: press scenarios plus hand-written stall/reset/repeat cases.
// Define KEY_AUTOREPEAT_EN on both bench and RTL to exercise the auto-repeat sequence.
module tb_key_instr_issuer;

  localparam int DEB  = 16;
  localparam int HOLD = 4;
  localparam int RPT  = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_code;
  logic       key_down;
  logic       ready;
  logic       new_instruction;
  logic [2:0] instruction;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Per-scenario observations.
  int         n_high;
  int         n_rises;
  int         n_err;
  int         bad_instr;
  int         first_rise;
  int         last_rise;
  logic       prev_new;
  logic [2:0] exp_instr;

  typedef struct {
    string      name;
    logic [3:0] code;
    int         len;
    logic [2:0] instr;
    int         high;
    int         rise;
    int         err;
  } vec_t;

  always #5 clk = ~clk;

  key_instr_issuer #(
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .CNT_W        (16),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_code       (key_code),
    .key_down       (key_down),
    .ready          (ready),
    .new_instruction(new_instruction),
    .instruction    (instruction),
    .busy           (busy),
    .err            (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats(input logic [2:0] instr);
    n_high     = 0;
    n_rises    = 0;
    n_err      = 0;
    bad_instr  = 0;
    first_rise = -1;
    last_rise  = -1;
    prev_new   = 1'b0;
    exp_instr  = instr;
  endtask

  task automatic sample(input int t);
    if (new_instruction === 1'b1) begin
      n_high++;
      if (instruction !== exp_instr) bad_instr++;
      if (!prev_new) begin
        n_rises++;
        last_rise = t;
        if (first_rise < 0) first_rise = t;
      end
    end
    if (err === 1'b1) n_err++;
    prev_new = new_instruction;
  endtask

  // Holds a key for len cycles (edge 0 = first sample of key_down=1), releases it and waits for busy to clear.
  task automatic run_press(input string name, input logic [3:0] code, input int len,
                           input logic [2:0] instr, input int high, input int rise, input int nerr);
    bit   done;
    logic busy_at_release;
    clear_stats(instr);
    key_code = code;
    key_down = 1'b1;
    for (int t = 0; t < len; t++) begin
      step();
      sample(t);
    end
    busy_at_release = busy;
    key_down = 1'b0;
    done = 1'b0;
    for (int t = len; t < len + 200 && !done; t++) begin
      step();
      sample(t);
      if (busy === 1'b0 && new_instruction === 1'b0) done = 1'b1;
    end
    check({name, " issue_cycles"}, n_high, high);
    check({name, " rise_cycle"}, first_rise, rise);
    check({name, " err_pulses"}, n_err, nerr);
    check({name, " instr_value"}, bad_instr, 0);
    check({name, " busy_held"}, busy_at_release, 1);
    check({name, " busy_clears"}, done, 1);
    step();
    step();
  endtask

  initial begin
    vec_t vecs[9];
    int   bad;
    bit   seen;

    vecs[0] = '{"clean_add",  4'h1, 60, 3'b001, HOLD, DEB + 2, 0};
    vecs[1] = '{"clrld",      4'h0, 30, 3'b000, HOLD, DEB + 2, 0};
    vecs[2] = '{"load",       4'h4, 30, 3'b100, HOLD, DEB + 2, 0};
    vecs[3] = '{"disp",       4'h3, 30, 3'b011, HOLD, DEB + 2, 0};
    vecs[4] = '{"unmapped_9", 4'h9, 40, 3'b101, 0,    -1,      1};
    vecs[5] = '{"unmapped_f", 4'hF, 40, 3'b101, 0,    -1,      1};
    vecs[6] = '{"unmapped_5", 4'h5, 20, 3'b101, 0,    -1,      1};
    vecs[7] = '{"short_17",   4'h1, 17, 3'b001, 0,    -1,      0};
    vecs[8] = '{"edge_18",    4'h2, 18, 3'b010, HOLD, DEB + 2, 0};

    rst      = 1'b1;
    key_down = 1'b0;
    key_code = 4'h0;
    ready    = 1'b1;
    step();
    step();
    check("reset new_instruction", new_instruction, 0);
    check("reset instruction", instruction, 3'b101);
    check("reset busy", busy, 0);
    check("reset err", err, 0);
    rst = 1'b0;
    bad = 0;
    for (int t = 0; t < 100; t++) begin
      step();
      if (new_instruction !== 1'b0 || instruction !== 3'b101 || busy !== 1'b0 || err !== 1'b0) bad++;
    end
    check("idle_hold deviations", bad, 0);

    for (int i = 0; i < 9; i++) begin
      run_press(vecs[i].name, vecs[i].code, vecs[i].len, vecs[i].instr,
                vecs[i].high, vecs[i].rise, vecs[i].err);
    end

    // Bounce: 5-cycle bursts never reach the debounce length.
    clear_stats(3'b100);
    key_code = 4'h4;
    for (int t = 0; t < 50; t++) begin
      key_down = ((t / 5) % 2) == 0;
      step();
      sample(t);
    end
    check("bounce issue_cycles", n_high, 0);
    check("bounce err_pulses", n_err, 0);
    run_press("bounce_settle", 4'h4, 40, 3'b100, HOLD, DEB + 2, 0);

    // Ready stall: a second key during WAIT_READY must never issue.
    ready = 1'b0;
    clear_stats(3'b010);
    key_code = 4'h2;
    key_down = 1'b1;
    for (int t = 0; t < 30; t++) begin step(); sample(t); end
    key_down = 1'b0;
    for (int t = 30; t < 50; t++) begin step(); sample(t); end
    key_code = 4'h3;
    key_down = 1'b1;
    for (int t = 50; t < 80; t++) begin step(); sample(t); end
    key_down = 1'b0;
    for (int t = 80; t < 100; t++) begin step(); sample(t); end
    check("stall rises", n_rises, 1);
    check("stall issue_cycles", n_high, HOLD);
    check("stall instr_value", bad_instr, 0);
    check("stall busy", busy, 1);
    ready = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      step();
      sample(t);
      if (busy === 1'b0) seen = 1'b1;
    end
    check("stall release_clears", seen, 1);
    check("stall no_late_issue", n_rises, 1);
    run_press("disp_fresh", 4'h3, 30, 3'b011, HOLD, DEB + 2, 0);

    // Reset on the second cycle of the hold window.
    clear_stats(3'b001);
    key_code = 4'h1;
    key_down = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      step();
      sample(t);
      if (new_instruction === 1'b1) seen = 1'b1;
    end
    check("rst_mid rise_cycle", first_rise, DEB + 2);
    rst      = 1'b1;
    key_down = 1'b0;
    step();
    check("rst_mid new_instruction", new_instruction, 0);
    check("rst_mid instruction", instruction, 3'b101);
    check("rst_mid busy", busy, 0);
    rst = 1'b0;
    clear_stats(3'b001);
    for (int t = 0; t < 30; t++) begin step(); sample(t); end
    check("rst_mid no_reissue", n_high, 0);

`ifdef KEY_AUTOREPEAT_EN
    // Held key repeats every DEB+... : rises at 18, 87, 156, 225, 294 with RPT=64.
    run_press("repeat_sub", 4'h2, 300, 3'b010, 5 * HOLD, DEB + 2, 0);
    check("repeat rises", n_rises, 5);
    check("repeat last_rise", last_rise, DEB + 2 + 4 * (RPT + HOLD + 1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
